uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Next-generation UART transmitter with parametrised frame format.
//   Configurable data width, parity, stop bits and bit period.
//   Includes a small TX FIFO so the CPU/console side can queue characters.
//   Sits between the PDP-8 teleprinter output logic and the board TX pin.
// PARAMETERS
//   CLK_DIV     11  clocks per bit period, >=1; each bit held exactly CLK_DIV clocks
//   DATA_BITS   8   data bits per frame, 5..9, sent LSB first
//   PARITY      0   0=none, 1=odd, 2=even (encodings defined in uart_pkg)
//   STOP_BITS   1   1 or 2
//   FIFO_DEPTH  4   TX FIFO entries, power of two, >=2
// PORTS
//   clk         in   1                        system clock
//   rst         in   1                        async reset, active high
//   tx_valid    in   1                        producer offers tx_data
//   tx_data     in   DATA_BITS                character to queue
//   tx_ready    out  1                        FIFO can accept; combinational = !full
//   tx          out  1                        serial line, idle high
//   busy        out  1                        frame in progress (state != IDLE)
//   fifo_level  out  $clog2(FIFO_DEPTH)+1     entries currently queued
// BEHAVIOUR
//   - Reset values: tx=1, tx_ready=1, busy=0, fifo_level=0. FSM=IDLE. FIFO flushed.
//   - Push when tx_valid && tx_ready at a clk edge. tx_data ignored otherwise.
//   - Full FIFO: tx_ready=0. A push is rejected even if a pop happens in the same cycle.
//   - Pop only when FIFO non-empty (registered count) and FSM is IDLE, or at the last
//     clock of the final stop bit. A push into an empty FIFO is popped on the next edge.
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START if the
//     FIFO is non-empty. Back-to-back frames have no idle gap.
//   - The bit timer reloads to CLK_DIV-1 on every pop and on every bit boundary.
//     It is not free-running, so the start bit is never shortened.
//   - Latency: accept at edge N into an empty FIFO while IDLE -> pop at edge N+1 ->
//     tx low from edge N+2.
//   - tx is driven from a register (no glitches). START drives 0.
//   - DATA sends shift_reg[0], then shifts right. A bit counter runs 0..DATA_BITS-1.
//   - Parity bit = ^data for even, ~^data for odd. It is computed at pop from the
//     latched word.
//   - STOP drives 1 for STOP_BITS*CLK_DIV clocks.
//   - fifo_level is updated on the same edge as the push/pop. With push and pop in one
//     cycle, level is unchanged.
//   - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The count is one bit
//     wider to distinguish full from empty.
//   - rst mid-frame: tx goes to 1 asynchronously. The frame is abandoned and the FIFO
//     contents are discarded. After release, the next accepted word starts a clean frame.
//   - PARITY/STOP_BITS/DATA_BITS out of range: elaboration-time $error.
// STRUCTURE
//   - uart_pkg contains:
//       - parity localparams PAR_NONE/PAR_ODD/PAR_EVEN
//       - FSM state enum (IDLE, START, DATA, PARITY, STOP)
//       - the frame-length helper function
//   - Sub-module sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full,
//     empty, level).
//   - Top level holds the FSM, bit timer, bit counter and shift register.
// TESTING (CLK_DIV=11 unless stated)
//   1. Reset -> tx=1, tx_ready=1, busy=0, fifo_level=0. Assert rst mid-idle: no
//      change to these outputs.
//   2. 8N1, push 0x55 -> tx low edges 2..12, then bits 1,0,1,0,1,0,1,0 at 11 clocks
//      each, then stop high. Frame is 110 clocks; busy falls after the stop bit.
//   3. Hold tx_valid with 8 words, FIFO_DEPTH=4 -> exactly 5 accepted before tx_ready
//      falls. Frames are contiguous with no idle clocks between stop and start.
//   4. DATA_BITS=7, PARITY=2, push 7'h03 -> parity bit 0. PARITY=1 gives 1.
//      STOP_BITS=2 -> tx held high 22 clocks.
//   5. Assert rst during data bit 3 -> tx=1 before the next edge, fifo_level=0.
//      Release, push 0xA5 -> a correct full frame is sent.
//   6. CLK_DIV=1, DATA_BITS=5 -> each bit lasts 1 clock. A 5N1 frame takes 7 clocks;
//      back-to-back frames still have no gaps.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity encodings,
// transmitter FSM states and a frame-length helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    // Clocks occupied by one complete frame on the line.
    function automatic int frame_clocks(input int clk_div, input int data_bits,
                                        input int parity, input int stop_bits);
        return clk_div * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read data and an occupancy count one bit
// wider than the pointers, so full and empty are unambiguous.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: flushing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small character queue in front of it. Frame format
// (data width, parity, stop bits) and bit period are fixed at elaboration.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 11,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("uart_tx_fifo: CLK_DIV must be at least 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_state_e          state, state_next;
    logic [TW-1:0]        timer, timer_next;
    logic [CW-1:0]        bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 par_bit, par_next;
    logic                 tx_next;
    logic                 start_frame;
    logic                 pop;
    logic                 bit_done;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;

    // tx_valid/tx_ready: a character transfers on every clk edge where both are
    // high; tx_ready depends only on the registered fill level, never on tx_valid.
    assign tx_ready = !fifo_full;
    assign busy     = (state != S_IDLE);
    assign bit_done = (timer == '0);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid && tx_ready),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        par_next     = par_bit;
        tx_next      = 1'b1;
        start_frame  = 1'b0;
        pop          = 1'b0;

        case (state)
            S_IDLE: begin
                start_frame = !fifo_empty;
            end
            S_START: begin
                tx_next = 1'b0;
                if (bit_done) begin
                    state_next   = S_DATA;
                    timer_next   = TIMER_MAX;
                    bit_cnt_next = '0;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_DATA: begin
                tx_next = shift_reg[0];
                if (bit_done) begin
                    shift_next = shift_reg >> 1;
                    timer_next = TIMER_MAX;
                    if (bit_cnt == LAST_DATA) begin
                        state_next   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + CW'(1);
                    end
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_PARITY: begin
                tx_next = par_bit;
                if (bit_done) begin
                    state_next   = S_STOP;
                    timer_next   = TIMER_MAX;
                    bit_cnt_next = '0;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (bit_cnt == LAST_STOP) begin
                        // Chain straight into the next start bit when work is queued.
                        if (fifo_empty) state_next = S_IDLE;
                        else            start_frame = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + CW'(1);
                        timer_next   = TIMER_MAX;
                    end
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (start_frame) begin
            pop          = 1'b1;
            state_next   = S_START;
            timer_next   = TIMER_MAX;
            bit_cnt_next = '0;
            shift_next   = fifo_dout;
            par_next     = (PARITY == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
        end
    end

    // tx is the registered image of the current state's line level, so it trails
    // the FSM by one clock and never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
            par_bit   <= par_next;
            tx        <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame formats side by side, a serial-line decoder
// per instance feeding a scoreboard, plus hand-timed latency and reset sequences.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic [3:0] tx_valid;
    logic [8:0] td [4];
    logic [3:0] tx_ready_w;
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [2:0] lvl [4];

    // Expected frames per instance: {parity bit, data}.
    logic [9:0] exp_q [4][$];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic       par;
    } vec_t;

    vec_t tbl [12];

    // dut0: 8N1, dut1: 7E2, dut2: 7O1, dut3: 5N1 at one clock per bit.
    uart_tx_fifo #(.CLK_DIV(11), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[0]), .tx_data(td[0][7:0]),
        .tx_ready(tx_ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_level(lvl[0]));
    uart_tx_fifo #(.CLK_DIV(11), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[1]), .tx_data(td[1][6:0]),
        .tx_ready(tx_ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_level(lvl[1]));
    uart_tx_fifo #(.CLK_DIV(11), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[2]), .tx_data(td[2][6:0]),
        .tx_ready(tx_ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_level(lvl[2]));
    uart_tx_fifo #(.CLK_DIV(1), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut3 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[3]), .tx_data(td[3][4:0]),
        .tx_ready(tx_ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_level(lvl[3]));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: offer one character, wait (bounded) for acceptance, record it.
    task automatic push(input int id, input logic [8:0] data, input logic par);
        int w;
        w = 0;
        @(negedge clk);
        tx_valid[id] = 1'b1;
        td[id]       = data;
        while (!tx_ready_w[id] && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("push_ready", 32'(tx_ready_w[id]), 32'd1);
        exp_q[id].push_back({par, data});
        @(posedge clk);
        #1 tx_valid[id] = 1'b0;
    endtask

    task automatic count_busy(input int id, input int limit, output int n);
        int w;
        w = 0;
        n = 0;
        @(negedge clk);
        while (!busy_w[id] && w < limit) begin
            @(negedge clk);
            w++;
        end
        while (busy_w[id] && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic take(input int id, output logic v, inout logic ab);
        @(negedge clk);
        v = tx_w[id];
        if (rst) ab = 1'b1;
    endtask

    // Line decoder: every bit must hold its level for exactly div samples.
    task automatic mon(input int id, input int div, input int db, input int par, input int sb);
        logic       v, w, ab, pbit;
        logic [8:0] data;
        logic [9:0] e;
        int         bad;
        forever begin
            @(negedge clk);
            if (!rst && tx_w[id] == 1'b0) begin
                ab  = 1'b0;
                bad = 0;
                for (int k = 1; k < div; k++) begin
                    take(id, v, ab);
                    if (v !== 1'b0) bad++;
                end
                data = '0;
                for (int b = 0; b < db; b++) begin
                    take(id, v, ab);
                    data[b] = v;
                    for (int k = 1; k < div; k++) begin
                        take(id, w, ab);
                        if (w !== v) bad++;
                    end
                end
                pbit = 1'b0;
                if (par != 0) begin
                    take(id, v, ab);
                    pbit = v;
                    for (int k = 1; k < div; k++) begin
                        take(id, w, ab);
                        if (w !== v) bad++;
                    end
                end
                for (int k = 0; k < sb * div; k++) begin
                    take(id, v, ab);
                    if (v !== 1'b1) bad++;
                end
                if (!ab) begin
                    if (exp_q[id].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame_unexpected: dut%0d sent %0h with nothing queued", id, data);
                    end else begin
                        e = exp_q[id].pop_front();
                        check($sformatf("frame_data_dut%0d", id), 32'(data), 32'(e[8:0]));
                        check($sformatf("frame_parity_dut%0d", id), 32'(pbit), 32'(e[9]));
                        check($sformatf("frame_bit_timing_dut%0d", id), 32'(bad), 32'd0);
                    end
                end
            end
        end
    endtask

    task automatic drain(input int limit);
        int w;
        w = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
               && w < limit) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        fork
            mon(0, 11, 8, 0, 1);
            mon(1, 11, 7, 2, 2);
            mon(2, 11, 7, 1, 1);
            mon(3, 1, 5, 0, 1);
        join_none
    end

    initial begin
        int nb, nb1, nb2, nb3, acc, n;
        logic stalled;
        logic [8:0] words [8];

        tbl[0]  = '{3, 9'h015, 1'b0};
        tbl[1]  = '{3, 9'h00A, 1'b0};
        tbl[2]  = '{3, 9'h01F, 1'b0};
        tbl[3]  = '{3, 9'h000, 1'b0};
        tbl[4]  = '{1, 9'h003, 1'b0};
        tbl[5]  = '{1, 9'h07F, 1'b1};
        tbl[6]  = '{1, 9'h007, 1'b1};
        tbl[7]  = '{1, 9'h041, 1'b0};
        tbl[8]  = '{2, 9'h003, 1'b1};
        tbl[9]  = '{2, 9'h000, 1'b1};
        tbl[10] = '{2, 9'h001, 1'b0};
        tbl[11] = '{2, 9'h015, 1'b0};

        rst      = 1'b1;
        tx_valid = '0;
        for (int i = 0; i < 4; i++) td[i] = '0;

        // Reset values, then a reset pulse while idle must change nothing.
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_w[0]), 32'd1);
        check("rst_tx_ready", 32'(tx_ready_w[0]), 32'd1);
        check("rst_busy", 32'(busy_w[0]), 32'd0);
        check("rst_level", 32'(lvl[0]), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_rst_tx", 32'(tx_w[0]), 32'd1);
        check("idle_rst_tx_ready", 32'(tx_ready_w[0]), 32'd1);
        check("idle_rst_busy", 32'(busy_w[0]), 32'd0);
        check("idle_rst_level", 32'(lvl[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 latency and exact start-bit / frame length.
        fork
            count_busy(0, 400, nb);
            begin
                @(negedge clk);
                tx_valid[0] = 1'b1;
                td[0]       = 9'h055;
                check("lat_ready", 32'(tx_ready_w[0]), 32'd1);
                exp_q[0].push_back({1'b0, 9'h055});
                @(negedge clk);
                tx_valid[0] = 1'b0;
                check("lat_level_after_push", 32'(lvl[0]), 32'd1);
                check("lat_busy_after_push", 32'(busy_w[0]), 32'd0);
                check("lat_tx_after_push", 32'(tx_w[0]), 32'd1);
                @(negedge clk);
                check("lat_busy_after_pop", 32'(busy_w[0]), 32'd1);
                check("lat_level_after_pop", 32'(lvl[0]), 32'd0);
                check("lat_tx_after_pop", 32'(tx_w[0]), 32'd1);
                @(negedge clk);
                n = 0;
                while (tx_w[0] == 1'b0 && n < 50) begin
                    n++;
                    @(negedge clk);
                end
                check("start_bit_len", 32'(n), 32'd11);
            end
        join
        check("frame_busy_len_8n1", 32'(nb), 32'd110);
        drain(500);

        // Hold tx_valid over 8 random words: 5 accepted before backpressure,
        // then 8 frames with no idle clock between them.
        for (int i = 0; i < 8; i++) words[i] = 9'($urandom_range(0, 255));
        fork
            count_busy(0, 2000, nb);
            begin
                acc     = 0;
                n       = 0;
                stalled = 1'b0;
                while (acc < 8 && n < 3000) begin
                    @(negedge clk);
                    n++;
                    tx_valid[0] = 1'b1;
                    td[0]       = words[acc];
                    if (tx_ready_w[0]) begin
                        exp_q[0].push_back({1'b0, words[acc]});
                        acc++;
                    end else if (!stalled) begin
                        stalled = 1'b1;
                        check("accepted_before_full", 32'(acc), 32'd5);
                        check("level_when_full", 32'(lvl[0]), 32'd4);
                    end
                end
                @(negedge clk);
                tx_valid[0] = 1'b0;
                check("burst_all_accepted", 32'(acc), 32'd8);
            end
        join
        check("burst_busy_len", 32'(nb), 32'd880);
        drain(2000);

        // Table of frame formats; busy length confirms stop length and no gaps.
        fork
            count_busy(1, 2000, nb1);
            count_busy(2, 2000, nb2);
            count_busy(3, 2000, nb3);
            begin
                for (int i = 0; i < 12; i++) push(tbl[i].dut, tbl[i].data, tbl[i].par);
            end
        join
        check("busy_len_7e2", 32'(nb1), 32'd484);
        check("busy_len_7o1", 32'(nb2), 32'd440);
        check("busy_len_5n1_div1", 32'(nb3), 32'd28);
        drain(2000);

        // Reset during data bit 3 of an all-zero character with one more queued.
        push(0, 9'h000, 1'b0);
        push(0, 9'h000, 1'b0);
        repeat (48) @(negedge clk);
        check("tx_low_before_rst", 32'(tx_w[0]), 32'd0);
        check("level_before_rst", 32'(lvl[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx_w[0]), 32'd1);
        check("mid_rst_level", 32'(lvl[0]), 32'd0);
        check("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        exp_q[0].delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (130) @(negedge clk);
        push(0, 9'h0A5, 1'b0);
        drain(500);

        for (int i = 0; i < 4; i++) check($sformatf("queue_empty_dut%0d", i), 32'(exp_q[i].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
